human_input_conditioner: RTL and testbench
==========================================

# human_input_conditioner

Conditions the board's human inputs before they reach the processor core and its IO module. It synchronizes the raw confirmation push-button and the slide switches to the core clock, and debounces the button with a counter-driven state machine. Each debounced press produces a single-cycle confirmation pulse and an atomic snapshot of the switch word. The snapshot is offered to the core through a valid/take handshake, so one press is consumed exactly once by an input instruction.

## Interface
- `IO_WIDTH`, default 16: switch word is `IO_WIDTH+1` bits (`[IO_WIDTH:0]`).
- `DEBOUNCE_CYCLES`, default 1000000: number of consecutive stable synchronized samples required to accept a level change (20 ms at 50 MHz). Legal range is ≥ 2.
- `clock` input, 1 bit: single clock; all state is on its rising edge.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `button_raw` input, 1 bit: raw confirmation button, active-low (0 = pressed), asynchronous.
- `sw_raw` input, `IO_WIDTH+1` bits: raw slide switches, asynchronous.
- `take` input, 1 bit: core consumes the snapshot (driven from `is_input`).
- `confirmation` output, 1 bit: debounced pressed level, 1 while held.
- `confirmation_pulse` output, 1 bit: one-cycle pulse on accepted press.
- `sw_live` output, `IO_WIDTH+1` bits: synchronized switches, not latched.
- `sw_data` output, `IO_WIDTH+1` bits: switch snapshot taken at the accepted press.
- `sw_valid` output, 1 bit: snapshot pending consumption.
- `overrun` output, 1 bit: sticky; a press was accepted while a snapshot was still pending.

## Operation
- **Synchronizers.** Two flip-flop stages per bit on `button_raw` and `sw_raw`. After the synchronizer, `pressed_s = ~button_sync`.
- **FSM states:** IDLE, PRESS_WAIT, HELD, RELEASE_WAIT. The counter is `$clog2(DEBOUNCE_CYCLES)` bits wide.
  - IDLE: if `pressed_s`, go to PRESS_WAIT with count = 1. Otherwise stay, with count held at 0.
  - PRESS_WAIT:
    - If `!pressed_s` (bounce): go to IDLE and clear count.
    - Else if count == DEBOUNCE_CYCLES-1: go to HELD, and assert `confirmation_pulse` for that one cycle.
    - Else: increment count.
  - HELD: if `!pressed_s`, go to RELEASE_WAIT with count = 1.
  - RELEASE_WAIT:
    - If `pressed_s`: go to HELD and clear count.
    - Else if count == DEBOUNCE_CYCLES-1: go to IDLE.
    - Else: increment count.
  - `confirmation` = 1 in HELD and RELEASE_WAIT.
- **Capture.** On the cycle `confirmation_pulse` is 1:
  - `sw_data` ← `sw_live` at that edge.
  - `sw_valid` ← 1.
  - If `sw_valid` was already 1 and `take` is 0, `overrun` ← 1.
- **Take.**
  - `take` with `sw_valid`=1 and no capture in the same cycle: `sw_valid` ← 0 and `overrun` ← 0. `sw_data` holds its value.
  - `take` with `sw_valid`=0 has no effect.
- **Simultaneous capture and take:** the capture wins. `sw_valid` stays 1 with the new data, and `overrun` is cleared, because the old word was consumed.
- **Reset (any time, including mid-debounce):**
  - State → IDLE, count = 0, synchronizers = released (1s for button, 0s for switches).
  - All outputs → 0; `sw_data` = 0.
  - A button held through reset release must complete a full PRESS_WAIT before it is accepted.

## Timing
- Latency from the first edge sampling a stable pressed `button_raw` to `confirmation_pulse`: 2 (sync) + DEBOUNCE_CYCLES cycles.
- `confirmation` rises in the same cycle as the pulse. It falls 2 + DEBOUNCE_CYCLES cycles after a stable release is first sampled.
- `sw_data`/`sw_valid` update at the edge ending the pulse cycle, so they are visible the cycle after the pulse.
- `sw_live` lags `sw_raw` by 2 cycles.
- `take` is sampled synchronously. `sw_valid` drops the cycle after `take`.
- Minimum spacing between two pulses is 2·DEBOUNCE_CYCLES cycles (press, release, press).
- No combinational path from any input to any output.

## Structure
- Package `armaria_input_pkg`:
  - FSM state enum (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT).
  - Constant `DEFAULT_DEBOUNCE_CYCLES = 1000000`.
  - Constant `SW_RESET_VALUE`.
- One sub-module, `sync_2ff`, parameterized by width and reset value, instantiated once for the button and once for the switches.
- The FSM, counter and capture/handshake logic live in the top module.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`.
- **Clean press.** `button_raw` 1→0 held 10 cycles, `sw_raw`=17'h0A5A5. Required: exactly one `confirmation_pulse` 6 cycles after the first sample, then `sw_data`=17'h0A5A5 and `sw_valid`=1.
- **Bounce rejection.** `button_raw` toggles 0,1,0,1 every 2 cycles, then stays at 1. Required: no pulse; `confirmation` stays 0; state returns to IDLE.
- **Take handshake.** After capture, assert `take` for 1 cycle. Required: `sw_valid`=0 the next cycle, and `sw_data` unchanged.
- **Overrun.** Perform two full presses with no `take`, with `sw_raw`=1 on the first and 2 on the second. Required: after the second capture, `sw_data`=2, `sw_valid`=1, `overrun`=1. A subsequent `take` clears both `sw_valid` and `overrun`.
- **Simultaneous capture and take.** Assert `take` in the pulse cycle while `sw_valid`=1. Required: `sw_valid` stays 1 with the new data, and `overrun`=0.
- **Reset mid-operation.** Assert `reset`=0 during PRESS_WAIT and during HELD. Required: all outputs 0 immediately (asynchronously). With the button still held after reset release, a pulse occurs only after 2+4 cycles.

Source files
------------

// File: rtl/armaria_input_pkg.sv
// Shared types and constants for the human input conditioning path.
package armaria_input_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } debounce_state_t;

    // 20 ms of stable level at a 50 MHz core clock.
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

    // Per-bit value the switch synchronizer holds while in reset.
    localparam logic SW_RESET_VALUE = 1'b0;

    // The button is active-low, so "released" is a 1 on the raw pin.
    localparam logic BUTTON_RESET_VALUE = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// Two-stage flip-flop synchronizer for asynchronous board inputs.
module sync_2ff #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Both stages return to the idle level on reset so no spurious edge is seen.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/human_input_conditioner.sv
// Synchronizes the confirmation button and slide switches, debounces the
// button, and hands one switch snapshot per accepted press to the core.
module human_input_conditioner
    import armaria_input_pkg::*;
#(
    parameter int IO_WIDTH        = 16,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                button_raw,
    input  logic [IO_WIDTH:0]   sw_raw,
    input  logic                take,
    output logic                confirmation,
    output logic                confirmation_pulse,
    output logic [IO_WIDTH:0]   sw_live,
    output logic [IO_WIDTH:0]   sw_data,
    output logic                sw_valid,
    output logic                overrun
);

    localparam int COUNT_WIDTH = $clog2(DEBOUNCE_CYCLES);
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE  = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_LAST = COUNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                   button_sync;
    logic                   pressed_s;
    logic                   accept_press;
    debounce_state_t        state;
    debounce_state_t        state_next;
    logic [COUNT_WIDTH-1:0] count;
    logic [COUNT_WIDTH-1:0] count_next;

    sync_2ff #(
        .WIDTH       (1),
        .RESET_VALUE (BUTTON_RESET_VALUE)
    ) button_sync_inst (
        .clock (clock),
        .reset (reset),
        .d     (button_raw),
        .q     (button_sync)
    );

    sync_2ff #(
        .WIDTH       (IO_WIDTH + 1),
        .RESET_VALUE ({(IO_WIDTH + 1){SW_RESET_VALUE}})
    ) sw_sync_inst (
        .clock (clock),
        .reset (reset),
        .d     (sw_raw),
        .q     (sw_live)
    );

    assign pressed_s = ~button_sync;

    // Debounce state and run-length counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // A level change is accepted only after an unbroken run of opposite samples.
    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            IDLE: begin
                if (pressed_s) begin
                    state_next = PRESS_WAIT;
                    count_next = COUNT_ONE;
                end else begin
                    count_next = '0;
                end
            end
            PRESS_WAIT: begin
                if (!pressed_s) begin
                    state_next = IDLE;
                    count_next = '0;
                end else if (count == COUNT_LAST) begin
                    state_next = HELD;
                    count_next = '0;
                end else begin
                    count_next = count + COUNT_ONE;
                end
            end
            HELD: begin
                if (!pressed_s) begin
                    state_next = RELEASE_WAIT;
                    count_next = COUNT_ONE;
                end else begin
                    count_next = '0;
                end
            end
            RELEASE_WAIT: begin
                if (pressed_s) begin
                    state_next = HELD;
                    count_next = '0;
                end else if (count == COUNT_LAST) begin
                    state_next = IDLE;
                    count_next = '0;
                end else begin
                    count_next = count + COUNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    // Debounced level follows the state; the press acceptance condition feeds the pulse register.
    always_comb begin
        confirmation = (state == HELD) || (state == RELEASE_WAIT);
        accept_press = (state == PRESS_WAIT) && pressed_s && (count == COUNT_LAST);
    end

    // Registering the pulse aligns it with the first HELD cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            confirmation_pulse <= 1'b0;
        end else begin
            confirmation_pulse <= accept_press;
        end
    end

    // Snapshot capture and valid/take handshake; a capture beats a same-cycle take.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sw_data  <= '0;
            sw_valid <= 1'b0;
            overrun  <= 1'b0;
        end else if (confirmation_pulse) begin
            sw_data  <= sw_live;
            sw_valid <= 1'b1;
            if (sw_valid) begin
                overrun <= ~take;
            end
        end else if (take && sw_valid) begin
            sw_valid <= 1'b0;
            overrun  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_human_input_conditioner.sv
// Self-checking bench: directed scenarios plus random button/switch/take
// traffic, compared every cycle against a run-length debounce model.
module tb_human_input_conditioner;

    localparam int IO_WIDTH = 16;
    localparam int DEBOUNCE = 4;
    localparam int W        = IO_WIDTH + 1;

    logic         clock      = 1'b0;
    logic         reset      = 1'b0;
    logic         button_raw = 1'b1;
    logic [W-1:0] sw_raw     = '0;
    logic         take       = 1'b0;

    logic         confirmation;
    logic         confirmation_pulse;
    logic [W-1:0] sw_live;
    logic [W-1:0] sw_data;
    logic         sw_valid;
    logic         overrun;

    int tests_run    = 0;
    int tests_failed = 0;
    bit check_en     = 1'b0;

    // Reference model state
    bit           m_btn_d1  = 1'b1;
    bit           m_btn_d2  = 1'b1;
    logic [W-1:0] m_sw_d1   = '0;
    logic [W-1:0] m_sw_d2   = '0;
    bit           m_level   = 1'b0;
    int           m_streak  = 0;
    bit           m_pulse   = 1'b0;
    bit           m_valid   = 1'b0;
    bit           m_overrun = 1'b0;
    logic [W-1:0] m_data    = '0;

    human_input_conditioner #(
        .IO_WIDTH        (IO_WIDTH),
        .DEBOUNCE_CYCLES (DEBOUNCE)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .button_raw         (button_raw),
        .sw_raw             (sw_raw),
        .take               (take),
        .confirmation       (confirmation),
        .confirmation_pulse (confirmation_pulse),
        .sw_live            (sw_live),
        .sw_data            (sw_data),
        .sw_valid           (sw_valid),
        .overrun            (overrun)
    );

    always #5 clock = ~clock;

    task automatic check_bit(input string name, input logic actual, input logic expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, actual, expected);
        end
    endtask

    task automatic check_word(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
        end
    endtask

    task automatic check_count(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic btn, input logic [W-1:0] sw, input logic tk);
        button_raw = btn;
        sw_raw     = sw;
        take       = tk;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check_all_zero(input string tag);
        check_bit({tag, "_confirmation"}, confirmation, 1'b0);
        check_bit({tag, "_pulse"}, confirmation_pulse, 1'b0);
        check_word({tag, "_sw_live"}, sw_live, '0);
        check_word({tag, "_sw_data"}, sw_data, '0);
        check_bit({tag, "_sw_valid"}, sw_valid, 1'b0);
        check_bit({tag, "_overrun"}, overrun, 1'b0);
    endtask

    // Full press then release, leaving the snapshot pending.
    task automatic press_release(input logic [W-1:0] sw);
        apply_stimulus(1'b0, sw, 1'b0);
        wait_cycles(9);
        apply_stimulus(1'b1, sw, 1'b0);
        wait_cycles(9);
    endtask

    // Reference model: the debounced level flips after DEBOUNCE consecutive
    // synchronized samples disagreeing with it; snapshot rules applied on the pulse.
    initial begin
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) begin
                m_btn_d1  = 1'b1;
                m_btn_d2  = 1'b1;
                m_sw_d1   = '0;
                m_sw_d2   = '0;
                m_level   = 1'b0;
                m_streak  = 0;
                m_pulse   = 1'b0;
                m_valid   = 1'b0;
                m_overrun = 1'b0;
                m_data    = '0;
            end else begin : model_step
                bit sample_pressed;
                bit new_pulse;
                sample_pressed = !m_btn_d2;
                new_pulse      = 1'b0;
                if (m_pulse) begin
                    if (m_valid) m_overrun = !take;
                    m_data  = m_sw_d2;
                    m_valid = 1'b1;
                end else if (take && m_valid) begin
                    m_valid   = 1'b0;
                    m_overrun = 1'b0;
                end
                if (sample_pressed != m_level) begin
                    m_streak++;
                    if (m_streak == DEBOUNCE) begin
                        m_level   = sample_pressed;
                        m_streak  = 0;
                        new_pulse = sample_pressed;
                    end
                end else begin
                    m_streak = 0;
                end
                m_pulse  = new_pulse;
                m_btn_d2 = m_btn_d1;
                m_btn_d1 = button_raw;
                m_sw_d2  = m_sw_d1;
                m_sw_d1  = sw_raw;
            end
        end
    end

    // Every cycle out of reset, all outputs must match the model.
    initial begin
        forever begin
            @(negedge clock);
            if (reset && check_en) begin
                check_bit("model_confirmation", confirmation, m_level);
                check_bit("model_pulse", confirmation_pulse, m_pulse);
                check_word("model_sw_live", sw_live, m_sw_d2);
                check_word("model_sw_data", sw_data, m_data);
                check_bit("model_sw_valid", sw_valid, m_valid);
                check_bit("model_overrun", overrun, m_overrun);
            end
        end
    end

    initial begin
        int pulses;
        int waited;
        bit conf_seen;
        int run_len;

        // Reset state
        reset = 1'b0;
        wait_cycles(3);
        check_all_zero("reset");
        reset    = 1'b1;
        check_en = 1'b1;
        wait_cycles(3);

        // Clean press: pulse on the 6th cycle after the first sampling edge
        apply_stimulus(1'b1, 17'h0A5A5, 1'b0);
        wait_cycles(3);
        apply_stimulus(1'b0, 17'h0A5A5, 1'b0);
        pulses = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            if (k == 5) check_bit("clean_no_early_pulse", confirmation_pulse, 1'b0);
            if (k == 6) begin
                check_bit("clean_pulse_at_6", confirmation_pulse, 1'b1);
                check_bit("clean_conf_rise", confirmation, 1'b1);
            end
            if (k == 7) begin
                check_word("clean_sw_data", sw_data, 17'h0A5A5);
                check_bit("clean_sw_valid", sw_valid, 1'b1);
            end
            pulses += int'(confirmation_pulse);
        end
        check_count("clean_pulse_count", pulses, 1);

        // Release: confirmation falls 6 cycles after the first released sample
        apply_stimulus(1'b1, 17'h0A5A5, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            if (k == 5) check_bit("release_conf_still_high", confirmation, 1'b1);
            if (k == 6) check_bit("release_conf_low", confirmation, 1'b0);
        end

        // Take handshake
        apply_stimulus(1'b1, 17'h0A5A5, 1'b1);
        wait_cycles(1);
        apply_stimulus(1'b1, 17'h0A5A5, 1'b0);
        check_bit("take_valid_low", sw_valid, 1'b0);
        check_word("take_data_held", sw_data, 17'h0A5A5);
        wait_cycles(2);

        // Bounce rejection
        pulses    = 0;
        conf_seen = 1'b0;
        for (int b = 0; b < 4; b++) begin
            button_raw = (b % 2 == 1);
            for (int c = 0; c < 2; c++) begin
                @(negedge clock);
                pulses += int'(confirmation_pulse);
                conf_seen |= confirmation;
            end
        end
        button_raw = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            pulses += int'(confirmation_pulse);
            conf_seen |= confirmation;
        end
        check_count("bounce_pulse_count", pulses, 0);
        check_bit("bounce_conf_never", conf_seen, 1'b0);

        // Overrun
        press_release(17'd1);
        check_word("overrun_first_data", sw_data, 17'd1);
        check_bit("overrun_first_flag", overrun, 1'b0);
        apply_stimulus(1'b0, 17'd2, 1'b0);
        wait_cycles(7);
        check_word("overrun_second_data", sw_data, 17'd2);
        check_bit("overrun_second_valid", sw_valid, 1'b1);
        check_bit("overrun_set", overrun, 1'b1);
        apply_stimulus(1'b1, 17'd2, 1'b0);
        wait_cycles(9);
        apply_stimulus(1'b1, 17'd2, 1'b1);
        wait_cycles(1);
        apply_stimulus(1'b1, 17'd2, 1'b0);
        check_bit("overrun_take_valid", sw_valid, 1'b0);
        check_bit("overrun_take_clear", overrun, 1'b0);
        wait_cycles(2);

        // Simultaneous capture and take, starting from an overrun condition
        press_release(17'd3);
        press_release(17'd5);
        check_bit("simul_pre_overrun", overrun, 1'b1);
        apply_stimulus(1'b0, 17'd4, 1'b0);
        waited = 0;
        while (!confirmation_pulse && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        check_bit("simul_pulse_seen", confirmation_pulse, 1'b1);
        take = 1'b1;
        wait_cycles(1);
        take = 1'b0;
        check_bit("simul_valid", sw_valid, 1'b1);
        check_word("simul_data", sw_data, 17'd4);
        check_bit("simul_overrun", overrun, 1'b0);
        apply_stimulus(1'b1, 17'd4, 1'b0);
        wait_cycles(9);

        // Reset during PRESS_WAIT with a snapshot pending
        apply_stimulus(1'b0, 17'h1FFFF, 1'b0);
        wait_cycles(3);
        #2 reset = 1'b0;
        #1 check_all_zero("rst_press_wait");
        @(negedge clock);
        reset = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            if (k == 5) check_bit("rst1_no_early_pulse", confirmation_pulse, 1'b0);
            if (k == 6) check_bit("rst1_pulse_at_6", confirmation_pulse, 1'b1);
        end

        // Reset during HELD
        wait_cycles(2);
        check_bit("rst_held_conf_before", confirmation, 1'b1);
        #2 reset = 1'b0;
        #1 check_all_zero("rst_held");
        @(negedge clock);
        reset = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            if (k == 5) check_bit("rst2_no_early_pulse", confirmation_pulse, 1'b0);
            if (k == 6) check_bit("rst2_pulse_at_6", confirmation_pulse, 1'b1);
        end
        apply_stimulus(1'b1, 17'h1FFFF, 1'b0);
        wait_cycles(9);

        // Random traffic: runs of button level, random switches and takes
        for (int r = 0; r < 400; r++) begin
            run_len    = $urandom_range(1, 12);
            button_raw = ($urandom_range(0, 1) == 1);
            for (int c = 0; c < run_len; c++) begin
                if ($urandom_range(0, 3) == 0) sw_raw = W'($urandom);
                take = ($urandom_range(0, 7) == 0);
                @(negedge clock);
            end
        end
        take = 1'b0;
        wait_cycles(2);

        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
